atom_mem_responder: RTL and testbench

Memory-side responder for the AtomRV32I core. It answers the core's instruction-fetch port (instr_address → instr) and data port (mem_addr/mem_out/mem_ctrl → mem_in) from one on-chip word array. It clears the array after reset, offers a load port for program images, and flags illegal accesses. It sits outside the core, in the SoC top and in the core testbench, as the other end of the core's memory interface.

---
 rtl/atom_mem_pkg.sv | 22 ++
 rtl/atom_mem_array.sv | 68 ++++++
 rtl/atom_mem_responder.sv | 175 +++++++++++++++++
 tb/tb_atom_mem_responder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/atom_mem_pkg.sv
// atom_mem_pkg
//   Definitions shared between the AtomRV32I core's data path and the
//   memory-side responder: the data-port command encoding, the NOP
//   instruction driven while memory is not serving, and the responder's
//   state encoding.
package atom_mem_pkg;

    // Data-port command encoding (mem_ctrl). The core's data cache uses the same values.
    localparam logic [1:0] MEM_IDLE  = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;
    localparam logic [1:0] MEM_RSVD  = 2'b11;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        CLEAR,
        READY
    } state_e;

endpackage

// File: rtl/atom_mem_array.sv
// atom_mem_array
//   DEPTH x XLEN word array with one write port and two registered read
//   ports. A read that hits the index being written in the same cycle
//   returns the new data (write-first). A read port only updates its output
//   register when its enable is high, so the last read value is held.
//
// Ports:
//   clk      in   clock
//   we       in   write enable
//   waddr    in   AW   write word index
//   wdata    in   XLEN write data
//   re_a     in   read enable, port A
//   raddr_a  in   AW   read word index, port A
//   rdata_a  out  XLEN registered read data, port A
//   re_b     in   read enable, port B
//   raddr_b  in   AW   read word index, port B
//   rdata_b  out  XLEN registered read data, port B
module atom_mem_array #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic            re_a,
    input  logic [AW-1:0]   raddr_a,
    output logic [XLEN-1:0] rdata_a,
    input  logic            re_b,
    input  logic [AW-1:0]   raddr_b,
    output logic [XLEN-1:0] rdata_b
);

    logic [XLEN-1:0] mem_q [DEPTH];
    logic [XLEN-1:0] rdata_a_q;
    logic [XLEN-1:0] rdata_b_q;
    logic [XLEN-1:0] rdata_a_d;
    logic [XLEN-1:0] rdata_b_d;

    // Bypass the write data so a same-cycle read sees the new word.
    always_comb begin
        rdata_a_d = mem_q[raddr_a];
        rdata_b_d = mem_q[raddr_b];
        if (we && (waddr == raddr_a)) begin
            rdata_a_d = wdata;
        end
        if (we && (waddr == raddr_b)) begin
            rdata_b_d = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        if (re_a) begin
            rdata_a_q <= rdata_a_d;
        end
        if (re_b) begin
            rdata_b_q <= rdata_b_d;
        end
    end

    assign rdata_a = rdata_a_q;
    assign rdata_b = rdata_b_q;

endmodule

// File: rtl/atom_mem_responder.sv
// atom_mem_responder
//   Memory-side responder for the AtomRV32I core. Serves the instruction
//   fetch port and the data port from one on-chip word array. After reset
//   the array is cleared one word per cycle (CLEAR); afterwards requests are
//   served with one cycle of read latency (READY). A load port writes
//   program images. Illegal accesses set a sticky err flag.
//
// Ports:
//   clk            in   clock
//   rst_n          in   synchronous active-low reset
//   instr_address  in   XLEN fetch byte address
//   instr          out  XLEN fetched instruction (NOP_INSTR when not serving)
//   mem_addr       in   XLEN data byte address
//   mem_out        in   XLEN store data
//   mem_ctrl       in   2    data command (IDLE/READ/WRITE/reserved)
//   mem_in         out  XLEN load data
//   ld_en          in   load-port write strobe
//   ld_addr        in   AW   load-port word index
//   ld_data        in   XLEN load-port word
//   init_done      out  array cleared, responder serving
//   err            out  sticky illegal-access flag
module atom_mem_responder
    import atom_mem_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] instr_address,
    output logic [XLEN-1:0] instr,
    input  logic [XLEN-1:0] mem_addr,
    input  logic [XLEN-1:0] mem_out,
    input  logic [1:0]      mem_ctrl,
    output logic [XLEN-1:0] mem_in,
    input  logic            ld_en,
    input  logic [AW-1:0]   ld_addr,
    input  logic [XLEN-1:0] ld_data,
    output logic            init_done,
    output logic            err
);

    localparam logic [XLEN-1:0] NopWord  = XLEN'(NOP_INSTR);
    localparam logic [AW-1:0]   LastIdx  = AW'(DEPTH - 1);

    state_e          state_q;
    logic [AW-1:0]   clr_idx_q;
    logic            init_done_q;
    logic            err_q;
    // Output masks: instr shows NOP_INSTR, mem_in shows 0 while set.
    logic            instr_nop_q;
    logic            mem_zero_q;

    logic [AW-1:0]   instr_idx;
    logic [AW-1:0]   data_idx;
    logic            instr_oor;
    logic            data_oor;
    logic            serving;
    logic            is_read;
    logic            is_write;
    logic            is_rsvd;
    logic            err_hit;

    logic            arr_we;
    logic [AW-1:0]   arr_waddr;
    logic [XLEN-1:0] arr_wdata;
    logic            fetch_re;
    logic            data_re;
    logic [XLEN-1:0] fetch_rdata;
    logic [XLEN-1:0] data_rdata;

    // Byte offset bits are ignored: all accesses are full words.
    logic            unused_byte_offs;
    assign unused_byte_offs = ^{instr_address[1:0], mem_addr[1:0]};

    assign instr_idx = instr_address[AW+1:2];
    assign data_idx  = mem_addr[AW+1:2];
    assign instr_oor = |instr_address[XLEN-1:AW+2];
    assign data_oor  = |mem_addr[XLEN-1:AW+2];

    // Request decode and write-port arbitration.
    always_comb begin
        serving  = (state_q == READY);
        is_read  = serving && (mem_ctrl == MEM_READ);
        is_write = serving && (mem_ctrl == MEM_WRITE);
        is_rsvd  = serving && (mem_ctrl == MEM_RSVD);

        arr_we    = 1'b0;
        arr_waddr = '0;
        arr_wdata = '0;
        if (!serving) begin
            arr_we    = 1'b1;
            arr_waddr = clr_idx_q;
            arr_wdata = '0;
        end else if (ld_en) begin
            // Load port wins over a coincident data write.
            arr_we    = 1'b1;
            arr_waddr = ld_addr;
            arr_wdata = ld_data;
        end else if (is_write && !data_oor) begin
            arr_we    = 1'b1;
            arr_waddr = data_idx;
            arr_wdata = mem_out;
        end

        fetch_re = serving && !instr_oor;
        data_re  = is_read && !data_oor;

        err_hit = ((is_read || is_write) && data_oor)
                || is_rsvd
                || (ld_en && is_write)
                || (serving && instr_oor);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= CLEAR;
            clr_idx_q   <= '0;
            init_done_q <= 1'b0;
            err_q       <= 1'b0;
            instr_nop_q <= 1'b1;
            mem_zero_q  <= 1'b1;
        end else begin
            unique case (state_q)
                CLEAR: begin
                    instr_nop_q <= 1'b1;
                    mem_zero_q  <= 1'b1;
                    if (clr_idx_q == LastIdx) begin
                        state_q     <= READY;
                        init_done_q <= 1'b1;
                    end else begin
                        clr_idx_q <= clr_idx_q + AW'(1);
                    end
                end
                READY: begin
                    instr_nop_q <= instr_oor;
                    // mem_in holds its value unless a READ is issued.
                    if (is_read) begin
                        mem_zero_q <= data_oor;
                    end
                    if (err_hit) begin
                        err_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= CLEAR;
                end
            endcase
        end
    end

    atom_mem_array #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk     (clk),
        .we      (arr_we),
        .waddr   (arr_waddr),
        .wdata   (arr_wdata),
        .re_a    (fetch_re),
        .raddr_a (instr_idx),
        .rdata_a (fetch_rdata),
        .re_b    (data_re),
        .raddr_b (data_idx),
        .rdata_b (data_rdata)
    );

    assign instr     = instr_nop_q ? NopWord : fetch_rdata;
    assign mem_in    = mem_zero_q ? '0 : data_rdata;
    assign init_done = init_done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_atom_mem_responder.sv
// tb_atom_mem_responder
//   Directed, table-driven bench for atom_mem_responder. Each table row is
//   one request cycle (optionally preceded by a full reset + clear) and the
//   outputs registered at that edge are compared with hand-computed values.
//   Hand-written sequences cover reset values, clear length and reset
//   during CLEAR.
module tb_atom_mem_responder;
    import atom_mem_pkg::*;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 1024;
    localparam int unsigned AW    = $clog2(DEPTH);

    logic            clk;
    logic            rst_n;
    logic [XLEN-1:0] instr_address;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_out;
    logic [1:0]      mem_ctrl;
    logic [XLEN-1:0] mem_in;
    logic            ld_en;
    logic [AW-1:0]   ld_addr;
    logic [XLEN-1:0] ld_data;
    logic            init_done;
    logic            err;

    int n_checks = 0;
    int n_fail   = 0;

    atom_mem_responder #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr_address (instr_address),
        .instr         (instr),
        .mem_addr      (mem_addr),
        .mem_out       (mem_out),
        .mem_ctrl      (mem_ctrl),
        .mem_in        (mem_in),
        .ld_en         (ld_en),
        .ld_addr       (ld_addr),
        .ld_data       (ld_data),
        .init_done     (init_done),
        .err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit            rst_before;
        bit            ld_en;
        logic [AW-1:0] ld_addr;
        logic [31:0]   ld_data;
        logic [31:0]   iaddr;
        logic [1:0]    ctrl;
        logic [31:0]   maddr;
        logic [31:0]   mout;
        logic [31:0]   e_instr;
        logic [31:0]   e_mem_in;
        bit            e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit rb, bit le, int unsigned la, logic [31:0] ld,
                                logic [31:0] ia, logic [1:0] c, logic [31:0] ma,
                                logic [31:0] mo, logic [31:0] ei, logic [31:0] em,
                                bit ee);
        vec_t v;
        v.rst_before = rb;
        v.ld_en      = le;
        v.ld_addr    = AW'(la);
        v.ld_data    = ld;
        v.iaddr      = ia;
        v.ctrl       = c;
        v.maddr      = ma;
        v.mout       = mo;
        v.e_instr    = ei;
        v.e_mem_in   = em;
        v.e_err      = ee;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        instr_address = '0;
        mem_addr      = '0;
        mem_out       = '0;
        mem_ctrl      = MEM_IDLE;
        ld_en         = 1'b0;
        ld_addr       = '0;
        ld_data       = '0;
    endtask

    // Reset for one edge, check reset values, then release and count clear
    // cycles while driving requests that must all be ignored.
    task automatic reset_and_clear(input string tag);
        int cycles;
        int nop_bad;
        rst_n = 1'b0;
        idle_inputs();
        step();
        check({tag, "_rst_instr"}, instr, NOP_INSTR);
        check({tag, "_rst_mem_in"}, mem_in, 32'h0);
        check({tag, "_rst_init_done"}, {31'h0, init_done}, 32'h0);
        check({tag, "_rst_err"}, {31'h0, err}, 32'h0);
        rst_n         = 1'b1;
        ld_en         = 1'b1;
        ld_addr       = '0;
        ld_data       = 32'hFFFF_FFFF;
        mem_ctrl      = MEM_RSVD;
        mem_addr      = 32'h0000_1000;
        instr_address = 32'h0000_1000;
        mem_out       = 32'hFFFF_FFFF;
        cycles  = 0;
        nop_bad = 0;
        while (!init_done && cycles < 2 * DEPTH) begin
            step();
            cycles++;
            if (!init_done && (instr !== NOP_INSTR || mem_in !== 32'h0)) nop_bad++;
        end
        check({tag, "_clear_cycles"}, 32'(cycles), 32'(DEPTH));
        check({tag, "_clear_outputs_bad"}, 32'(nop_bad), 32'h0);
        check({tag, "_clear_err"}, {31'h0, err}, 32'h0);
        idle_inputs();
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();

        //          rb le la ld_data        iaddr          ctrl       maddr          mout           e_instr        e_mem_in       e_err
        vecs.push_back(mk(0, 0, 0, 32'h0,         32'h0,         MEM_READ,  32'h10,        32'h0,         32'h0,         32'h0,         0));
        vecs.push_back(mk(0, 1, 4, 32'hDEADBEEF,  32'h0,         MEM_IDLE,  32'h0,         32'h0,         32'h0,         32'h0,         0));
        vecs.push_back(mk(0, 0, 0, 32'h0,         32'h10,        MEM_IDLE,  32'h0,         32'h0,         32'hDEADBEEF,  32'h0,         0));
        vecs.push_back(mk(0, 0, 0, 32'h0,         32'h20,        MEM_WRITE, 32'h20,        32'h12345678,  32'h12345678,  32'h0,         0));
        vecs.push_back(mk(0, 0, 0, 32'h0,         32'h10,        MEM_READ,  32'h20,        32'h0,         32'hDEADBEEF,  32'h12345678,  0));
        vecs.push_back(mk(0, 0, 0, 32'h0,         32'h20,        MEM_IDLE,  32'h0,         32'h0,         32'h12345678,  32'h12345678,  0));
        vecs.push_back(mk(0, 0, 0, 32'h0,         32'h24,        MEM_WRITE, 32'h24,        32'hA5A5A5A5,  32'hA5A5A5A5,  32'h12345678,  0));
        vecs.push_back(mk(0, 0, 0, 32'h0,         32'h12,        MEM_READ,  32'h27,        32'h0,         32'hDEADBEEF,  32'hA5A5A5A5,  0));
        vecs.push_back(mk(0, 1, 4, 32'h11112222,  32'h10,        MEM_READ,  32'h10,        32'h0,         32'h11112222,  32'h11112222,  0));
        // Out-of-range data accesses.
        vecs.push_back(mk(1, 0, 0, 32'h0,         32'h0,         MEM_READ,  32'h1000,      32'h0,         32'h0,         32'h0,         1));
        vecs.push_back(mk(0, 0, 0, 32'h0,         32'h0,         MEM_WRITE, 32'h1000,      32'h55555555,  32'h0,         32'h0,         1));
        vecs.push_back(mk(0, 0, 0, 32'h0,         32'h0,         MEM_READ,  32'h0,         32'h0,         32'h0,         32'h0,         1));
        // Load port colliding with a data write.
        vecs.push_back(mk(1, 1, 2, 32'hAAAA0002,  32'h8,         MEM_WRITE, 32'h8,         32'hBBBB0008,  32'hAAAA0002,  32'h0,         1));
        vecs.push_back(mk(0, 0, 0, 32'h0,         32'h0,         MEM_READ,  32'h8,         32'h0,         32'h0,         32'hAAAA0002,  1));
        // Reserved command: err set, mem_in held.
        vecs.push_back(mk(1, 1, 1, 32'h00000077,  32'h0,         MEM_IDLE,  32'h0,         32'h0,         32'h0,         32'h0,         0));
        vecs.push_back(mk(0, 0, 0, 32'h0,         32'h4,         MEM_READ,  32'h4,         32'h0,         32'h77,        32'h77,        0));
        vecs.push_back(mk(0, 0, 0, 32'h0,         32'h4,         MEM_RSVD,  32'h4,         32'h0,         32'h77,        32'h77,        1));
        // Out-of-range fetch and high-bit addresses.
        vecs.push_back(mk(1, 0, 0, 32'h0,         32'h1000,      MEM_IDLE,  32'h0,         32'h0,         NOP_INSTR,     32'h0,         1));
        vecs.push_back(mk(0, 1, 5, 32'h00000099,  32'h0,         MEM_IDLE,  32'h0,         32'h0,         32'h0,         32'h0,         1));
        vecs.push_back(mk(0, 0, 0, 32'h0,         32'h14,        MEM_READ,  32'h14,        32'h0,         32'h99,        32'h99,        1));
        vecs.push_back(mk(0, 0, 0, 32'h0,         32'h80000014,  MEM_READ,  32'h80000014,  32'h0,         NOP_INSTR,     32'h0,         1));

        reset_and_clear("init");

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst_before) reset_and_clear($sformatf("vec%0d", i));
            ld_en         = vecs[i].ld_en;
            ld_addr       = vecs[i].ld_addr;
            ld_data       = vecs[i].ld_data;
            instr_address = vecs[i].iaddr;
            mem_ctrl      = vecs[i].ctrl;
            mem_addr      = vecs[i].maddr;
            mem_out       = vecs[i].mout;
            step();
            check($sformatf("vec%0d_instr", i), instr, vecs[i].e_instr);
            check($sformatf("vec%0d_mem_in", i), mem_in, vecs[i].e_mem_in);
            check($sformatf("vec%0d_err", i), {31'h0, err}, {31'h0, vecs[i].e_err});
        end
        idle_inputs();

        // Reset mid-traffic then mid-CLEAR: err clears, array re-cleared.
        ld_en   = 1'b1;
        ld_addr = AW'(3);
        ld_data = 32'h33333333;
        step();
        idle_inputs();
        mem_ctrl = MEM_READ;
        mem_addr = 32'hC;
        step();
        check("seq_word3_loaded", mem_in, 32'h33333333);
        check("seq_err_sticky", {31'h0, err}, 32'h1);
        rst_n = 1'b0;
        idle_inputs();
        step();
        check("seq_rst_err", {31'h0, err}, 32'h0);
        check("seq_rst_init_done", {31'h0, init_done}, 32'h0);
        rst_n = 1'b1;
        repeat (100) step();
        check("seq_clear100_init_done", {31'h0, init_done}, 32'h0);
        check("seq_clear100_instr", instr, NOP_INSTR);
        reset_and_clear("midclr");
        mem_ctrl = MEM_READ;
        mem_addr = 32'hC;
        step();
        check("seq_word3_cleared", mem_in, 32'h0);
        check("seq_err_after", {31'h0, err}, 32'h0);
        idle_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
